// File: rtl/datapath.sv
// 8-bit datapath: 16x8 register file (r0 hardwired to zero) with two
// asynchronous read ports feeding an 8-operation combinational ALU.
module datapath (
   input  logic       clk,
   input  logic       rst,
   input  logic       alu_en,
   input  logic [2:0] alu_opcode,
   input  logic [7:0] user_write_data,
   input  logic [3:0] write_addr,
   input  logic [3:0] ra_addr,
   input  logic [3:0] rb_addr,
   input  logic       write_en,
   output logic [7:0] read_a,
   output logic [7:0] read_b,
   output logic       alu_zero,
   output logic       alu_carry
);

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_NOT = 3'b101,
      OP_SHL = 3'b110,
      OP_SHR = 3'b111
   } alu_op_e;

   logic [7:0] regs_q [16];
   logic [7:0] regs_d [16];
   logic [7:0] alu_result;
   logic [7:0] write_data;
   logic [8:0] sum9;
   logic [8:0] diff9;

   assign read_a = regs_q[ra_addr];
   assign read_b = regs_q[rb_addr];

   // diff9[8] is the borrow: set exactly when read_a < read_b unsigned.
   assign sum9  = {1'b0, read_a} + {1'b0, read_b};
   assign diff9 = {1'b0, read_a} - {1'b0, read_b};

   always_comb begin
      alu_result = 8'h00;
      alu_carry  = 1'b0;
      case (alu_op_e'(alu_opcode))
         OP_ADD: begin
            alu_result = sum9[7:0];
            alu_carry  = sum9[8];
         end
         OP_SUB: begin
            alu_result = diff9[7:0];
            alu_carry  = diff9[8];
         end
         OP_AND: alu_result = read_a & read_b;
         OP_OR:  alu_result = read_a | read_b;
         OP_XOR: alu_result = read_a ^ read_b;
         OP_NOT: alu_result = ~read_a;
         OP_SHL: begin
            alu_result = {read_a[6:0], 1'b0};
            alu_carry  = read_a[7];
         end
         OP_SHR: begin
            alu_result = {1'b0, read_a[7:1]};
            alu_carry  = read_a[0];
         end
         default: ;
      endcase
   end

   assign alu_zero   = (alu_result == 8'h00);
   assign write_data = alu_en ? alu_result : user_write_data;

   always_comb begin
      regs_d = regs_q;
      if (write_en && (write_addr != 4'd0)) begin
         regs_d[write_addr] = write_data;
      end
      // r0 is pinned to zero so reads of it need no special-case mux.
      regs_d[0] = 8'h00;
   end

   // NOTE: the register array is reset because clearing every entry is part
   // of the block's visible behaviour, not just a convenience for simulation.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 16; i++) begin
            regs_q[i] <= 8'h00;
         end
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values.
         regs_q <= regs_d;
      end
   end

endmodule

// File: tb/tb_datapath.sv
// Scoreboard bench for datapath: stimulus queues expected read/flag values,
// a monitor pops and compares them on each falling clock edge.
module tb_datapath;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       alu_en = 1'b0;
   logic [2:0] alu_opcode = 3'b000;
   logic [7:0] user_write_data = 8'h00;
   logic [3:0] write_addr = 4'd0;
   logic [3:0] ra_addr = 4'd0;
   logic [3:0] rb_addr = 4'd0;
   logic       write_en = 1'b0;
   logic [7:0] read_a;
   logic [7:0] read_b;
   logic       alu_zero;
   logic       alu_carry;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      name;
      logic [7:0] a;
      logic [7:0] b;
      logic       z;
      logic       c;
      bit         chk_a;
      bit         chk_b;
      bit         chk_f;
   } exp_t;

   exp_t exp_q[$];

   localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011,
                          XOR_ = 3'b100, NOT_ = 3'b101, SHL = 3'b110, SHR = 3'b111;

   datapath dut (
      .clk             (clk),
      .rst             (rst),
      .alu_en          (alu_en),
      .alu_opcode      (alu_opcode),
      .user_write_data (user_write_data),
      .write_addr      (write_addr),
      .ra_addr         (ra_addr),
      .rb_addr         (rb_addr),
      .write_en        (write_en),
      .read_a          (read_a),
      .read_b          (read_b),
      .alu_zero        (alu_zero),
      .alu_carry       (alu_carry)
   );

   always #5 clk = ~clk;

   // Monitor: every falling edge, drain and compare all pending expectations.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (e.chk_a && read_a !== e.a) begin
               errors++;
               $display("FAIL %s: read_a=%h expected %h", e.name, read_a, e.a);
            end else if (e.chk_b && read_b !== e.b) begin
               errors++;
               $display("FAIL %s: read_b=%h expected %h", e.name, read_b, e.b);
            end else if (e.chk_f && (alu_zero !== e.z || alu_carry !== e.c)) begin
               errors++;
               $display("FAIL %s: zero/carry=%b/%b expected %b/%b",
                        e.name, alu_zero, alu_carry, e.z, e.c);
            end
         end
      end
   end

   task automatic push(input string name, input logic [7:0] a, input logic [7:0] b,
                       input logic z, input logic c,
                       input bit ca, input bit cb, input bit cf);
      exp_t e;
      e.name = name; e.a = a; e.b = b; e.z = z; e.c = c;
      e.chk_a = ca; e.chk_b = cb; e.chk_f = cf;
      exp_q.push_back(e);
      @(negedge clk);
      #1;
   endtask

   task automatic expect_ab(input string name, input logic [7:0] a, input logic [7:0] b);
      push(name, a, b, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
   endtask

   task automatic expect_a(input string name, input logic [7:0] a);
      push(name, a, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic expect_fl(input string name, input logic z, input logic c);
      push(name, 8'h00, 8'h00, z, c, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic wr(input logic [3:0] addr, input logic [7:0] data);
      write_en = 1'b1; alu_en = 1'b0;
      write_addr = addr; user_write_data = data;
      @(posedge clk);
      #1;
      write_en = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      string      name;
      logic [2:0] op;
      logic [7:0] res;
      logic       c;
   } op_vec_t;

   op_vec_t ops[6];

   initial begin
      logic [7:0] ea, eb;
      ops[0] = '{"AND", AND_, 8'h01, 1'b0};
      ops[1] = '{"OR",  OR_,  8'h8F, 1'b0};
      ops[2] = '{"XOR", XOR_, 8'h8E, 1'b0};
      ops[3] = '{"NOT", NOT_, 8'h7E, 1'b0};
      ops[4] = '{"SHL", SHL,  8'h02, 1'b1};
      ops[5] = '{"SHR", SHR,  8'h40, 1'b1};

      // Reset held: every register and the ADD flags read as zero operands.
      #2;
      for (int i = 0; i < 16; i++) begin
         ra_addr = 4'(i); rb_addr = 4'(15 - i);
         push("reset_read", 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      end
      alu_opcode = SUB;
      expect_fl("reset_sub_flags", 1'b1, 1'b0);
      alu_opcode = ADD;

      tick();
      rst = 1'b1;

      // Fill and cross sweep.
      for (int i = 0; i < 16; i++) wr(4'(i), 8'(i * 17));
      for (int i = 0; i < 16; i++) begin
         ra_addr = 4'(i); rb_addr = 4'(15 - i);
         ea = (i == 0) ? 8'h00 : 8'(i * 17);
         eb = (i == 15) ? 8'h00 : 8'(( 15 - i) * 17);
         expect_ab("fill_sweep", ea, eb);
      end

      // Overwrite, r0 immunity, write-enable gating.
      wr(4'd3, 8'hAA);
      ra_addr = 4'd3; rb_addr = 4'd3;
      expect_ab("overwrite_r3", 8'hAA, 8'hAA);
      wr(4'd0, 8'h77);
      ra_addr = 4'd0; rb_addr = 4'd0;
      expect_ab("r0_hardwired", 8'h00, 8'h00);
      write_en = 1'b0; write_addr = 4'd5; user_write_data = 8'h11;
      tick();
      ra_addr = 4'd5;
      expect_a("we_gating_r5", 8'h55);
      alu_en = 1'b1; write_en = 1'b0; write_addr = 4'd5; alu_opcode = NOT_;
      tick();
      expect_a("alu_en_no_we_r5", 8'h55);

      // ADD accumulate r1 += r2 for 64 clocks.
      wr(4'd1, 8'h00);
      wr(4'd2, 8'h01);
      ra_addr = 4'd1; rb_addr = 4'd2; write_addr = 4'd1;
      alu_opcode = ADD; alu_en = 1'b1; write_en = 1'b1;
      for (int k = 0; k < 64; k++) begin
         push("add_acc", 8'(k), 8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
         tick();
      end
      write_en = 1'b0;
      expect_a("add_acc_final", 8'h40);

      // SUB wrap: r12 -= r6 for 25 clocks; borrow only on the 13th step.
      wr(4'd12, 8'h7F);
      wr(4'd6, 8'h0A);
      ra_addr = 4'd12; rb_addr = 4'd6; write_addr = 4'd12;
      alu_opcode = SUB; alu_en = 1'b1; write_en = 1'b1;
      for (int k = 0; k < 25; k++) begin
         push("sub_wrap", 8'(127 - 10 * k), 8'h0A, 1'b0, (k == 12), 1'b1, 1'b1, 1'b1);
         tick();
      end
      write_en = 1'b0;
      expect_a("sub_wrap_final", 8'h85);

      // Remaining ops on A=0x81, B=0x0F, result written back to r9.
      wr(4'd7, 8'h81);
      wr(4'd8, 8'h0F);
      foreach (ops[i]) begin
         ra_addr = 4'd7; rb_addr = 4'd8; write_addr = 4'd9;
         alu_opcode = ops[i].op; alu_en = 1'b1; write_en = 1'b1;
         expect_fl({ops[i].name, "_flags"}, (ops[i].res == 8'h00), ops[i].c);
         tick();
         write_en = 1'b0;
         ra_addr = 4'd9;
         expect_a({ops[i].name, "_result"}, ops[i].res);
      end
      wr(4'd10, 8'hFF);
      wr(4'd11, 8'h01);
      ra_addr = 4'd10; rb_addr = 4'd11; write_addr = 4'd9;
      alu_opcode = ADD; alu_en = 1'b1; write_en = 1'b1;
      expect_fl("add_ff_01_flags", 1'b1, 1'b1);
      tick();
      write_en = 1'b0;
      ra_addr = 4'd9;
      expect_a("add_ff_01_result", 8'h00);

      // Async reset in the middle of an ADD accumulate loop.
      wr(4'd1, 8'h00);
      wr(4'd2, 8'h01);
      ra_addr = 4'd1; rb_addr = 4'd2; write_addr = 4'd1;
      alu_opcode = ADD; alu_en = 1'b1; write_en = 1'b1;
      repeat (5) tick();
      #1;
      rst = 1'b0;
      push("async_reset_now", 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      alu_en = 1'b0; user_write_data = 8'h5A;
      tick();
      expect_ab("no_write_in_reset", 8'h00, 8'h00);
      write_en = 1'b0;
      rst = 1'b1;
      tick();
      expect_ab("after_reset_release", 8'h00, 8'h00);

      // Bounded drain of the scoreboard before the summary.
      repeat (4) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/datapath.md
# datapath

8-bit processor datapath combining a 16-entry register file with an 8-operation ALU. Two asynchronous read ports feed the ALU. A single synchronous write port stores either externally supplied data or the ALU result. It sits between the control unit (opcode, enables, addresses) and the rest of the core, and exports the read data and the ALU status flags.

## Interface
- Parameters: none. Data width is fixed at 8 bits, register address width at 4 bits (16 registers).
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk` input 1: sole clock, rising-edge active.
- `rst` input 1: asynchronous active-low reset; clears all registers.
- `alu_en` input 1: write-data select; 1 = ALU result, 0 = `user_write_data`.
- `alu_opcode` input 3: ALU operation select.
- `user_write_data` input 8: external write data.
- `write_addr` input 4: write port register index.
- `ra_addr` input 4: read port A index.
- `rb_addr` input 4: read port B index.
- `write_en` input 1: write strobe, sampled on the rising `clk` edge.
- `read_a` output 8: register[`ra_addr`], combinational; ALU operand A.
- `read_b` output 8: register[`rb_addr`], combinational; ALU operand B.
- `alu_zero` output 1: 1 when the ALU result is 0x00.
- `alu_carry` output 1: ALU carry/borrow/shift-out flag.

## Operation
- **Register file:** 16 × 8 bits. Register 0 is hardwired to 0x00; writes to it are ignored and reads of it always return 0x00.
- **Reads:** both ports are asynchronous and independent; both may address the same register.
- **Write:** on a rising `clk` edge with `write_en`=1 and `write_addr`≠0, register[`write_addr`] ← write data, where write data = `alu_en` ? `alu_result` : `user_write_data`.
  - `alu_en` without `write_en` causes no write.
- **ALU:** purely combinational on A=`read_a`, B=`read_b`. The result is truncated to 8 bits.
  - 000 ADD: A+B; carry = bit 8 of the 9-bit sum.
  - 001 SUB: A−B (mod 256); carry = borrow (1 when A<B unsigned).
  - 010 AND: A&B; carry = 0.
  - 011 OR: A|B; carry = 0.
  - 100 XOR: A^B; carry = 0.
  - 101 NOT: ~A (B ignored); carry = 0.
  - 110 SHL: A<<1, zero fill; carry = A[7].
  - 111 SHR: A>>1, logical, zero fill; carry = A[0].
- **Flags:** `alu_zero` and `alu_carry` are combinational from the current operands and opcode. They are valid regardless of `alu_en` and are not registered.

## Timing
- **Reset:** while `rst`=0, all 16 registers are 0x00 immediately, independent of `clk`. `read_a`/`read_b` are therefore 0x00.
  - The flags then reflect the 0x00 operands under the current opcode: e.g. ADD gives zero=1, carry=0.
  - Reset deassertion is synchronised by the integrator; the first write takes effect on the first rising edge with `rst`=1.
- **Write latency:** 1 cycle. Data is visible on a read port addressing that register immediately after the edge; before the edge the old value is read (no write-through bypass).
- **Read latency:** 0 cycles; combinational from address and register contents.
- **Feedback loop:** an ALU result written back to a source register updates once per clock. The new value propagates combinationally to the next result before the following edge.
- **Reset mid-operation:** it overrides any write in progress; the register contents are lost.

## Test plan
- **Reset then fill:** reset, then write i×0x11 to registers 0..15 → all read 0x00 after reset; then reg i = i×0x11 for i≥1, reg0 = 0x00. Sweep `ra_addr`=i and `rb_addr`=15−i asynchronously and confirm the values with no clock dependency.
- **Overwrite and write-enable gating:**
  - Write 0xAA to reg3 → `read_a`=`read_b`=0xAA.
  - Write any value to reg0 → still 0x00.
  - `write_en`=0 with `write_addr`=5, data 0x11 → reg5 stays 0x55.
- **ADD accumulate:** reg1=0x00, reg2=0x01, `ra`=1, `rb`=2, `write_addr`=1, `alu_en`=1, ADD, 64 clocks → reg1 = 0x40; carry 0 throughout.
- **SUB wrap:** reg12=0x7F, reg6=0x0A, `ra`=12, `rb`=6, `write_addr`=12, SUB, 25 clocks → reg12 = 0x85.
  - Carry=1 only while A<0x0A, first when A=0x07 (13th subtraction) → 0xFD.
  - `alu_zero` never asserted.
- **Remaining ops** (A=0x81, B=0x0F):
  - AND → 0x01
  - OR → 0x8F
  - XOR → 0x8E
  - NOT → 0x7E
  - SHL → 0x02, carry 1
  - SHR → 0x40, carry 1
  - ADD 0xFF+0x01 → 0x00, zero 1, carry 1
- **Async reset mid-run:** pull `rst` low between clock edges during the ADD loop → all reads 0x00 immediately, with no write on the next edge while low.
